// File: rtl/sim_run_sequencer_if.sv
// Control and observation bundle between the run-control side and sim_run_sequencer.
interface sim_run_sequencer_if #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned KEY_WIDTH   = 4,
    parameter int unsigned SW_WIDTH    = 10,
    parameter int unsigned NUM_STEPS   = 4,
    parameter int unsigned DELAY_WIDTH = 16
);
    localparam int unsigned AW = $clog2(NUM_STEPS);

    logic                   start;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic                   wr_valid;
    logic [DELAY_WIDTH-1:0] wr_delay;
    logic [KEY_WIDTH-1:0]   wr_key;
    logic [SW_WIDTH-1:0]    wr_sw;
    logic [PC_WIDTH-1:0]    pc;
    logic                   core_reset_n;
    logic [KEY_WIDTH-1:0]   key;
    logic [SW_WIDTH-1:0]    sw;
    logic                   busy;
    logic                   done;
    logic                   halted;
    logic                   timeout;
    logic [31:0]            cycle_count;

    modport master (
        output start, wr_en, wr_addr, wr_valid, wr_delay, wr_key, wr_sw, pc,
        input  core_reset_n, key, sw, busy, done, halted, timeout, cycle_count
    );

    modport slave (
        input  start, wr_en, wr_addr, wr_valid, wr_delay, wr_key, wr_sw, pc,
        output core_reset_n, key, sw, busy, done, halted, timeout, cycle_count
    );
endinterface

// File: rtl/sim_run_sequencer.sv
// Scripted run controller for the core: reset hold, timed KEY/SW stimulus,
// PC-stuck halt detection and a RUN-cycle timeout.
module sim_run_sequencer #(
    parameter int unsigned PC_WIDTH       = 32,
    parameter int unsigned KEY_WIDTH      = 4,
    parameter int unsigned SW_WIDTH       = 10,
    parameter int unsigned NUM_STEPS      = 4,
    parameter int unsigned DELAY_WIDTH    = 16,
    parameter int unsigned RESET_CYCLES   = 10,
    parameter int unsigned STABLE_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input logic                CLOCK_50,
    input logic                RESET,
    sim_run_sequencer_if.slave bus
);
    localparam int unsigned AW  = $clog2(NUM_STEPS);
    localparam int unsigned HW  = $clog2(RESET_CYCLES + 1);
    localparam int unsigned SCW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD_RST, S_RUN, S_DONE} state_e;

    typedef struct packed {
        logic                   valid;
        logic [DELAY_WIDTH-1:0] delay;
        logic [KEY_WIDTH-1:0]   key;
        logic [SW_WIDTH-1:0]    sw;
    } step_t;

    state_e                 state_q, state_d;
    step_t                  script_q [NUM_STEPS];
    step_t                  script_d [NUM_STEPS];
    logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic                   script_end_q, script_end_d;
    logic [DELAY_WIDTH-1:0] dly_cnt_q, dly_cnt_d;
    logic                   first_q, first_d;
    logic [PC_WIDTH-1:0]    pc_prev_q, pc_prev_d;
    logic [SCW-1:0]         stable_q, stable_d;
    logic [31:0]            cycle_count_q, cycle_count_d;
    logic                   core_reset_n_q, core_reset_n_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic [SW_WIDTH-1:0]    sw_q, sw_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   halted_q, halted_d;
    logic                   timeout_q, timeout_d;

    step_t                  cur;
    logic [31:0]            cyc_next;

    always_comb begin
        state_d        = state_q;
        script_d       = script_q;
        hold_cnt_d     = hold_cnt_q;
        ptr_d          = ptr_q;
        script_end_d   = script_end_q;
        dly_cnt_d      = dly_cnt_q;
        first_d        = first_q;
        pc_prev_d      = pc_prev_q;
        stable_d       = stable_q;
        cycle_count_d  = cycle_count_q;
        core_reset_n_d = core_reset_n_q;
        key_d          = key_q;
        sw_d           = sw_q;
        busy_d         = busy_q;
        done_d         = done_q;
        halted_d       = halted_q;
        timeout_d      = timeout_q;
        cur            = script_q[ptr_q];
        cyc_next       = (cycle_count_q == 32'hFFFF_FFFF) ? cycle_count_q
                                                          : cycle_count_q + 32'd1;

        // Script writes land before a same-cycle start so the new entry is used.
        if ((state_q == S_IDLE || state_q == S_DONE) && bus.wr_en) begin
            script_d[bus.wr_addr] = '{valid: bus.wr_valid, delay: bus.wr_delay,
                                      key: bus.wr_key, sw: bus.wr_sw};
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d        = S_HOLD_RST;
                    hold_cnt_d     = '0;
                    core_reset_n_d = 1'b0;
                    key_d          = '0;
                    sw_d           = '0;
                    busy_d         = 1'b1;
                    done_d         = 1'b0;
                    halted_d       = 1'b0;
                    timeout_d      = 1'b0;
                    cycle_count_d  = '0;
                end
            end
            S_HOLD_RST: begin
                if (hold_cnt_q == HW'(RESET_CYCLES - 1)) begin
                    state_d        = S_RUN;
                    core_reset_n_d = 1'b1;
                    ptr_d          = '0;
                    script_end_d   = 1'b0;
                    dly_cnt_d      = '0;
                    first_d        = 1'b1;
                    stable_d       = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            S_RUN: begin
                first_d       = 1'b0;
                pc_prev_d     = bus.pc;
                cycle_count_d = cyc_next;

                // First RUN cycle only seeds pc_prev; comparisons start after.
                if (first_q) begin
                    stable_d = '0;
                end else if (bus.pc == pc_prev_q) begin
                    stable_d = (stable_q < SCW'(STABLE_CYCLES)) ? stable_q + SCW'(1) : stable_q;
                end else begin
                    stable_d = '0;
                end

                if (!script_end_q) begin
                    if (!cur.valid) begin
                        script_end_d = 1'b1;
                    end else if (dly_cnt_q == cur.delay) begin
                        key_d     = cur.key;
                        sw_d      = cur.sw;
                        dly_cnt_d = '0;
                        if (ptr_q == AW'(NUM_STEPS - 1)) begin
                            script_end_d = 1'b1;
                        end else begin
                            ptr_d = ptr_q + AW'(1);
                        end
                    end else begin
                        dly_cnt_d = dly_cnt_q + DELAY_WIDTH'(1);
                    end
                end

                // Halt takes priority when both end conditions hit together.
                if (stable_q == SCW'(STABLE_CYCLES)) begin
                    halted_d = 1'b1;
                    state_d  = S_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else if (cyc_next >= 32'(TIMEOUT_CYCLES)) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q        <= S_IDLE;
            for (int i = 0; i < int'(NUM_STEPS); i++) script_q[i] <= '0;
            hold_cnt_q     <= '0;
            ptr_q          <= '0;
            script_end_q   <= 1'b0;
            dly_cnt_q      <= '0;
            first_q        <= 1'b0;
            pc_prev_q      <= '0;
            stable_q       <= '0;
            cycle_count_q  <= '0;
            core_reset_n_q <= 1'b0;
            key_q          <= '0;
            sw_q           <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            halted_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            script_q       <= script_d;
            hold_cnt_q     <= hold_cnt_d;
            ptr_q          <= ptr_d;
            script_end_q   <= script_end_d;
            dly_cnt_q      <= dly_cnt_d;
            first_q        <= first_d;
            pc_prev_q      <= pc_prev_d;
            stable_q       <= stable_d;
            cycle_count_q  <= cycle_count_d;
            core_reset_n_q <= core_reset_n_d;
            key_q          <= key_d;
            sw_q           <= sw_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            halted_q       <= halted_d;
            timeout_q      <= timeout_d;
        end
    end

    assign bus.core_reset_n = core_reset_n_q;
    assign bus.key          = key_q;
    assign bus.sw           = sw_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.halted       = halted_q;
    assign bus.timeout      = timeout_q;
    assign bus.cycle_count  = cycle_count_q;
endmodule

// File: tb/tb_sim_run_sequencer.sv
// Directed bench for sim_run_sequencer: timeout, halt, script timing, priority,
// async reset abort and restart, with hand-computed expectations.
module tb_sim_run_sequencer;
    localparam int unsigned RC = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    sim_run_sequencer_if #(.PC_WIDTH(32), .KEY_WIDTH(4), .SW_WIDTH(10),
                           .NUM_STEPS(4), .DELAY_WIDTH(16)) bus_if ();

    sim_run_sequencer #(
        .PC_WIDTH(32), .KEY_WIDTH(4), .SW_WIDTH(10), .NUM_STEPS(4), .DELAY_WIDTH(16),
        .RESET_CYCLES(RC), .STABLE_CYCLES(8), .TIMEOUT_CYCLES(50)
    ) dut (
        .CLOCK_50(clk),
        .RESET   (rst),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // pc stimulus for RUN cycle r (r=1 is the first RUN cycle).
    function automatic logic [31:0] pc_of(input int mode, input int r);
        case (mode)
            0:       return 32'(4 * (r - 1));
            1:       return (r >= 9) ? 32'h20 : 32'(4 * (r - 1));
            2:       return (r >= 41) ? 32'(160) : 32'(4 * (r - 1));
            default: return 32'h100;
        endcase
    endfunction

    task automatic write_step(input int addr, input logic v, input logic [15:0] d,
                              input logic [3:0] k, input logic [9:0] s);
        bus_if.wr_addr  = 2'(addr);
        bus_if.wr_valid = v;
        bus_if.wr_delay = d;
        bus_if.wr_key   = k;
        bus_if.wr_sw    = s;
    endtask

    // Pulses start and checks the reset hold; returns just after the RUN-entry edge.
    task automatic start_run(input string tag);
        int lows;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        bus_if.wr_en = 1'b0;
        chk({tag, "_busy"}, 32'(bus_if.busy), 32'd1);
        chk({tag, "_done_clr"}, 32'(bus_if.done), 32'd0);
        chk({tag, "_flags_clr"}, {30'd0, bus_if.halted, bus_if.timeout}, 32'd0);
        chk({tag, "_cyc_clr"}, bus_if.cycle_count, 32'd0);
        lows = (bus_if.core_reset_n == 1'b0) ? 1 : 0;
        for (int i = 1; i < int'(RC); i++) begin
            tick();
            if (bus_if.core_reset_n == 1'b0) lows++;
        end
        chk({tag, "_rst_low_cycles"}, 32'(lows), 32'(RC));
        tick();
        chk({tag, "_rst_release"}, 32'(bus_if.core_reset_n), 32'd1);
    endtask

    // Advances RUN cycles with the given pc pattern until done or budget expiry.
    task automatic run_to_done(input int mode, output int n);
        n = 0;
        bus_if.pc = pc_of(mode, 1);
        while (bus_if.done !== 1'b1 && n < 200) begin
            tick();
            n++;
            bus_if.pc = pc_of(mode, n + 1);
        end
    endtask

    initial begin
        int n;
        bus_if.start    = 1'b0;
        bus_if.wr_en    = 1'b0;
        bus_if.pc       = '0;
        write_step(0, 1'b0, 16'd0, 4'h0, 10'h0);

        // Reset values
        tick();
        tick();
        chk("rst_core_reset_n", 32'(bus_if.core_reset_n), 32'd0);
        chk("rst_busy_done", {30'd0, bus_if.busy, bus_if.done}, 32'd0);
        chk("rst_key_sw", {18'd0, bus_if.key, bus_if.sw}, 32'd0);
        chk("rst_cycle_count", bus_if.cycle_count, 32'd0);
        rst = 1'b0;
        tick();

        // Empty script, incrementing pc: ends by timeout
        start_run("t1");
        run_to_done(0, n);
        chk("t1_edges", 32'(n), 32'd50);
        chk("t1_done", 32'(bus_if.done), 32'd1);
        chk("t1_timeout", 32'(bus_if.timeout), 32'd1);
        chk("t1_halted", 32'(bus_if.halted), 32'd0);
        chk("t1_cycle_count", bus_if.cycle_count, 32'd50);
        chk("t1_busy", 32'(bus_if.busy), 32'd0);
        chk("t1_core_reset_n", 32'(bus_if.core_reset_n), 32'd1);

        // Restart from DONE, pc climbs to 0x20 then holds: halt
        start_run("t2");
        run_to_done(1, n);
        chk("t2_halted", 32'(bus_if.halted), 32'd1);
        chk("t2_timeout", 32'(bus_if.timeout), 32'd0);
        chk("t2_cycle_count", bus_if.cycle_count, 32'd18);

        // Scripted stimulus, plus a write attempted during RUN
        write_step(0, 1'b1, 16'd0, 4'h1, 10'h000); bus_if.wr_en = 1'b1; tick();
        write_step(1, 1'b1, 16'd5, 4'h0, 10'h3FF); tick();
        write_step(2, 1'b0, 16'd0, 4'h0, 10'h000); tick();
        bus_if.wr_en = 1'b0;
        start_run("t3");
        chk("t3_key_entry", {28'd0, bus_if.key}, 32'h0);
        bus_if.pc = 32'h100;
        for (int i = 1; i <= 10; i++) begin
            if (i == 2) begin
                write_step(2, 1'b1, 16'd0, 4'hA, 10'h155);
                bus_if.wr_en = 1'b1;
            end
            if (i == 3) bus_if.wr_en = 1'b0;
            tick();
            if (i == 1) chk("t3_step0_key", {28'd0, bus_if.key}, 32'h1);
            if (i == 1) chk("t3_step0_sw", {22'd0, bus_if.sw}, 32'h0);
            if (i == 6) chk("t3_step1_early", {28'd0, bus_if.key}, 32'h1);
            if (i == 7) chk("t3_step1_key", {28'd0, bus_if.key}, 32'h0);
            if (i == 7) chk("t3_step1_sw", {22'd0, bus_if.sw}, 32'h3FF);
            if (i == 9) chk("t3_hold_key", {28'd0, bus_if.key}, 32'h0);
        end
        chk("t3_halted", 32'(bus_if.halted), 32'd1);
        chk("t3_cycle_count", bus_if.cycle_count, 32'd10);

        // Halt and timeout on the same cycle; script reused, RUN write was dropped
        start_run("t4");
        run_to_done(2, n);
        chk("t4_halted", 32'(bus_if.halted), 32'd1);
        chk("t4_timeout", 32'(bus_if.timeout), 32'd0);
        chk("t4_cycle_count", bus_if.cycle_count, 32'd50);
        chk("t4_key_hold", {28'd0, bus_if.key}, 32'h0);
        chk("t4_sw_hold", {22'd0, bus_if.sw}, 32'h3FF);

        // Write in the start cycle is used; then async RESET mid-run
        write_step(0, 1'b1, 16'd0, 4'h5, 10'h000);
        bus_if.wr_en = 1'b1;
        start_run("t5");
        bus_if.pc = 32'h100;
        tick();
        chk("t5_new_entry_key", {28'd0, bus_if.key}, 32'h5);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t5_abort_core_reset_n", 32'(bus_if.core_reset_n), 32'd0);
        chk("t5_abort_key", {28'd0, bus_if.key}, 32'h0);
        chk("t5_abort_busy_done", {30'd0, bus_if.busy, bus_if.done}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Script cleared by reset: key/sw stay 0 through a full run
        start_run("t6");
        run_to_done(3, n);
        chk("t6_halted", 32'(bus_if.halted), 32'd1);
        chk("t6_cycle_count", bus_if.cycle_count, 32'd10);
        chk("t6_key_sw", {18'd0, bus_if.key, bus_if.sw}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sim_run_sequencer.md
# sim_run_sequencer

Parametrised run controller for the processor top level: drives the core's board-level inputs (RESET_N, KEY, SW) from a small programmable script and watches the fetch-stage PC to decide when a program run is finished. It replaces a fixed reset-release-then-free-run sequence with scripted key/switch stimulus, halt detection (PC stuck) and a cycle timeout. It sits between the run-control logic (or a bench) and the Project instance.

## Interface
- PC_WIDTH, 32, width of observed PC.
- KEY_WIDTH, 4, width of KEY stimulus.
- SW_WIDTH, 10, width of SW stimulus.
- NUM_STEPS, 4, script depth (power of two, ≥2).
- DELAY_WIDTH, 16, width of per-step delay field.
- RESET_CYCLES, 10, cycles the core is held in reset after start (≥1).
- STABLE_CYCLES, 8, consecutive equal-PC comparisons that declare halt (≥1).
- TIMEOUT_CYCLES, 100000, RUN-cycle limit (≥1).

- CLOCK_50  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; honoured in IDLE or DONE only.
- wr_en  in  1  script write strobe; honoured in IDLE or DONE only.
- wr_addr  in  log2(NUM_STEPS)  script entry index.
- wr_valid  in  1  entry valid bit.
- wr_delay  in  DELAY_WIDTH  cycles to wait before applying this entry.
- wr_key  in  KEY_WIDTH  KEY value applied by entry.
- wr_sw  in  SW_WIDTH  SW value applied by entry.
- pc  in  PC_WIDTH  fetch-stage PC from the core.
- core_reset_n  out  1  active-low reset to the core.
- key  out  KEY_WIDTH  KEY stimulus to the core.
- sw  out  SW_WIDTH  SW stimulus to the core.
- busy  out  1  high in HOLD_RST or RUN.
- done  out  1  high in DONE.
- halted  out  1  run ended by PC halt.
- timeout  out  1  run ended by timeout.
- cycle_count  out  32  RUN cycles elapsed in current/last run.

## Operation
- States: IDLE, HOLD_RST, RUN, DONE.
- Reset: state IDLE, core_reset_n=0, key=0, sw=0, busy=0, done=0, halted=0, timeout=0, cycle_count=0, all script valid bits 0. RESET mid-run aborts immediately to these values.
- IDLE/DONE + start: → HOLD_RST; clears halted, timeout, done, cycle_count; key, sw ← 0. start and wr_en same cycle: write takes effect, then run starts (new entry is used).
- HOLD_RST: core_reset_n=0 for exactly RESET_CYCLES cycles, then → RUN.
- RUN: core_reset_n=1; step pointer starts at 0; delay counter starts at 0 on first RUN cycle.
  - Entry at pointer valid and delay counter == its wr_delay: key/sw load entry values next edge, pointer++, delay counter ← 0. Delay 0 applies on first RUN cycle.
  - Invalid entry or pointer past NUM_STEPS−1: script ends, key/sw hold last values.
  - cycle_count increments every RUN cycle, saturates at 2^32−1.
  - Halt detect: pc_prev sampled each RUN cycle; stable counter +1 when pc==pc_prev, else 0; first RUN cycle only loads pc_prev (no compare). stable == STABLE_CYCLES → halted=1, → DONE.
  - cycle_count reaching TIMEOUT_CYCLES → timeout=1, → DONE.
  - Both same cycle: halted=1, timeout=0 (halt wins).
- DONE: core_reset_n stays 1, key/sw hold, flags held until next start or RESET.
- Writes in HOLD_RST/RUN ignored.

## Timing
- All outputs registered; no combinational input→output paths.
- start at edge N → busy=1, core_reset_n=0 after edge N; core_reset_n=1 after edge N+RESET_CYCLES.
- Halt flagged one cycle after the STABLE_CYCLES-th equal comparison; done asserts same edge as halted/timeout.
- Step with delay d applied d+1 edges after the previous step's application (or after RUN entry).

## Test plan
- Reset then start, empty script, pc increments by 4 each cycle, TIMEOUT_CYCLES=50 → core_reset_n low 10 cycles, timeout=1, done=1, cycle_count=50, halted=0.
- pc counts 0x0,0x4,…,0x20 then holds 0x20, STABLE_CYCLES=8 → halted=1 exactly 8 comparisons after first 0x20 repeat, timeout=0.
- Script {delay 0: key=0x1 sw=0x0; delay 5: key=0x0 sw=0x3FF; entry2 invalid} → key=0x1 in first RUN cycle, key=0x0/sw=0x3FF six cycles later, then hold.
- Halt and timeout coincide (PC held so stable hits 8 at cycle_count 50, TIMEOUT 50) → halted=1, timeout=0.
- RESET asserted in RUN with key=0x1 → immediately IDLE, core_reset_n=0, key=0, done=0, script cleared; wr_en during RUN ignored (entry unchanged on readback via subsequent run).
- Restart from DONE with start → flags cleared, cycle_count=0, full HOLD_RST repeated.
